dm_access_unit: RTL and testbench

- Load/store sequencer directly upstream of the 1024x8 data memory (DM).
- Accepts one 8- or 16-bit load/store request per transaction over a valid/ready handshake.
- Computes the effective address, drives the DM write-enable, address and data.
- Captures DM read data, splitting 16-bit accesses into two little-endian byte cycles, then returns a response over a valid/ready handshake.

---
 rtl/dm_access_pkg.sv | 26 ++
 rtl/dm_access_unit.sv | 156 +++++++++++++++
 tb/tb_dm_access_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_access_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : dm_access_pkg
// Purpose : Shared constants and types for the data-memory access unit.
//           AW/DW describe the 1024x8 data memory, state_t enumerates the
//           load/store sequencer states.
// Revision: 1.0 - initial release
// ============================================================================
package dm_access_pkg;

  localparam int AW = 10;   // DM address width (1024 bytes)
  localparam int DW = 8;    // DM data width

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef logic [AW-1:0] dm_addr_t;
  typedef logic [15:0]   half_t;

endpackage : dm_access_pkg
`default_nettype wire

// File: rtl/dm_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : dm_access_unit
// Purpose : Load/store sequencer in front of the 1024x8 data memory. Accepts
//           one 8/16-bit request, forms the effective address, drives the DM
//           port for one (narrow) or two (wide, little-endian) byte cycles and
//           returns the load result over a valid/ready handshake.
// Ports   :
//   i_clk, i_rst_n       clock / asynchronous active-low reset
//   i_req_*  / o_req_ready   request handshake and fields
//   o_rsp_valid / i_rsp_ready / o_rsp_rdata   response handshake and data
//   o_dm_en, o_dm_addr, o_dm_in, i_dm_out     data-memory port
// Revision: 1.0 - initial release
// ============================================================================
module dm_access_unit
  import dm_access_pkg::*;
#(
  parameter int AW = dm_access_pkg::AW,
  parameter int DW = dm_access_pkg::DW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  // request channel
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_we,
  input  logic          i_req_wide,
  input  logic          i_req_signed,
  input  logic [AW-1:0] i_req_base,
  input  logic [7:0]    i_req_offset,
  input  logic [15:0]   i_req_wdata,
  // response channel
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [15:0]   o_rsp_rdata,
  // data-memory port
  output logic          o_dm_en,
  output logic [AW-1:0] o_dm_addr,
  output logic [DW-1:0] o_dm_in,
  input  logic [DW-1:0] i_dm_out
);

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_we;
  logic          r_wide;
  logic          r_signed;
  logic [AW-1:0] r_ea;
  half_t         r_wdata;
  half_t         r_rdata;
  // Selects which byte lane the DM port presents; set on entering ACC_HI,
  // cleared on entering ACC_LO, so outside the access states the port keeps
  // showing whatever it drove last.
  logic          r_hi;

  logic [AW-1:0] w_ea;
  logic [AW-1:0] w_ea_p1;
  logic          w_accept;

  // Offset is sign-extended to the address width; the sum naturally wraps
  // modulo 2**AW.
  assign w_ea     = i_req_base + {{(AW-8){i_req_offset[7]}}, i_req_offset};
  assign w_ea_p1  = r_ea + {{(AW-1){1'b0}}, 1'b1};
  assign w_accept = (r_state == IDLE) && i_req_valid;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_req_valid) w_state_nxt = ACC_LO;
      ACC_LO:  w_state_nxt = r_wide ? ACC_HI : RESP;
      ACC_HI:  w_state_nxt = RESP;
      RESP:    if (i_rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_wide   <= 1'b0;
      r_signed <= 1'b0;
      r_ea     <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_hi     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_we     <= i_req_we;
        r_wide   <= i_req_wide;
        r_signed <= i_req_signed;
        r_ea     <= w_ea;
        r_wdata  <= i_req_wdata;
      end

      if (w_state_nxt == ACC_LO) begin
        r_hi <= 1'b0;
      end else if (w_state_nxt == ACC_HI) begin
        r_hi <= 1'b1;
      end

      // DM read data is combinational, so it is valid for the address
      // presented during the current access cycle.
      if (r_state == ACC_LO && !r_we) begin
        r_rdata[7:0] <= i_dm_out;
      end
      if (r_state == ACC_HI && !r_we) begin
        r_rdata[15:8] <= i_dm_out;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Moore outputs
  // --------------------------------------------------------------------------
  always_comb begin
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_dm_en     = 1'b0;
    case (r_state)
      IDLE:    o_req_ready = 1'b1;
      ACC_LO:  o_dm_en     = r_we;
      ACC_HI:  o_dm_en     = r_we;
      RESP:    o_rsp_valid = 1'b1;
      default: o_req_ready = 1'b0;
    endcase
  end

  assign o_dm_addr = r_hi ? w_ea_p1 : r_ea;
  assign o_dm_in   = r_hi ? r_wdata[15:8] : r_wdata[7:0];

  always_comb begin
    o_rsp_rdata = 16'h0000;
    if (!r_we) begin
      if (r_wide) begin
        o_rsp_rdata = r_rdata;
      end else if (r_signed) begin
        o_rsp_rdata = {{8{r_rdata[7]}}, r_rdata[7:0]};
      end else begin
        o_rsp_rdata = {8'h00, r_rdata[7:0]};
      end
    end
  end

endmodule : dm_access_unit
`default_nettype wire

// File: tb/tb_dm_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_dm_access_unit
// Purpose : Self-checking bench for dm_access_unit. A byte-array memory sits
//           on the DM port; a reference byte array plus arithmetic address
//           and extension rules give the expected memory contents, DM port
//           activity and load results.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_wide = 1'b0;
  logic        req_signed = 1'b0;
  logic [9:0]  req_base = '0;
  logic [7:0]  req_offset = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_rdata;
  logic        dm_en;
  logic [9:0]  dm_addr;
  logic [7:0]  dm_in;
  logic [7:0]  dm_out;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  mem     [1024];
  logic [7:0]  ref_mem [1024];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [7:0]  pl_data = '0;

  always #5 clk = ~clk;

  dm_access_unit dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_wide   (req_wide),
    .i_req_signed (req_signed),
    .i_req_base   (req_base),
    .i_req_offset (req_offset),
    .i_req_wdata  (req_wdata),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_rdata  (rsp_rdata),
    .o_dm_en      (dm_en),
    .o_dm_addr    (dm_addr),
    .o_dm_in      (dm_in),
    .i_dm_out     (dm_out)
  );

  // Data memory: combinational read, synchronous write, with a preload port.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (dm_en) mem[dm_addr] <= dm_in;
  end
  assign dm_out = mem[dm_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int calc_ea(input logic [9:0] base, input logic [7:0] off);
    int v;
    v = int'(base) + int'($signed(off));
    return ((v % 1024) + 1024) % 1024;
  endfunction

  // One complete transaction with bp cycles of response back-pressure.
  task automatic do_req(input bit we, input bit wide, input bit sgn,
                        input logic [9:0] base, input logic [7:0] off,
                        input logic [15:0] wd, input int bp);
    int          ea, ea1;
    logic [15:0] exp;
    logic [7:0]  b;
    ea  = calc_ea(base, off);
    ea1 = (ea + 1) % 1024;
    if (we) exp = 16'h0000;
    else if (wide) exp = {ref_mem[ea1], ref_mem[ea]};
    else begin
      b = ref_mem[ea];
      exp = sgn ? {{8{b[7]}}, b} : {8'h00, b};
    end

    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_wide = wide; req_signed = sgn;
    req_base = base; req_offset = off; req_wdata = wd; rsp_ready = 1'b0;
    @(posedge clk); #1;
    // Scramble the request fields: the unit must work from its latched copy.
    req_valid = 1'b0; req_we = ~we; req_wide = ~wide; req_signed = ~sgn;
    req_base = 10'($urandom); req_offset = 8'($urandom); req_wdata = 16'($urandom);

    @(negedge clk);
    chk("lo_dm_en", dm_en, we);
    chk("lo_dm_addr", dm_addr, ea);
    chk("lo_dm_in", dm_in, wd[7:0]);
    chk("lo_rsp_valid", rsp_valid, 0);
    chk("lo_req_ready", req_ready, 0);
    if (wide) begin
      @(negedge clk);
      chk("hi_dm_en", dm_en, we);
      chk("hi_dm_addr", dm_addr, ea1);
      chk("hi_dm_in", dm_in, wd[15:8]);
      chk("hi_rsp_valid", rsp_valid, 0);
    end

    @(negedge clk);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, exp);
    chk("rsp_dm_en", dm_en, 0);
    chk("rsp_dm_addr_hold", dm_addr, wide ? ea1 : ea);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_rdata", rsp_rdata, exp);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_dm_en", dm_en, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_req_ready", req_ready, 1);
    chk("post_dm_en", dm_en, 0);

    if (we) begin
      ref_mem[ea] = wd[7:0];
      if (wide) ref_mem[ea1] = wd[15:8];
    end
    chk("mem_lo", mem[ea], ref_mem[ea]);
    chk("mem_hi", mem[ea1], ref_mem[ea1]);
  endtask

  initial begin
    int bad;

    // Preload memory with random contents while held in reset.
    rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_addr = 10'(i); pl_data = 8'($urandom);
      ref_mem[i] = pl_data;
    end
    @(negedge clk);
    pl_en = 1'b0;

    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_dm_en", dm_en, 0);
    chk("rst_dm_addr", dm_addr, 0);
    chk("rst_dm_in", dm_in, 0);
    rst_n = 1'b1;

    // Narrow store then unsigned narrow load.
    do_req(1, 0, 0, 10'd10, 8'h00, 16'h00A5, 0);
    do_req(0, 0, 0, 10'd10, 8'h00, 16'h0000, 0);
    // Signed / unsigned narrow load of 0x80.
    do_req(1, 0, 0, 10'd3, 8'h00, 16'h0080, 0);
    do_req(0, 0, 1, 10'd3, 8'h00, 16'h0000, 0);
    do_req(0, 0, 0, 10'd3, 8'h00, 16'h0000, 0);
    // Wide store wrapping from 1023 to 0, then wide load.
    do_req(1, 1, 0, 10'd1023, 8'h00, 16'hBEEF, 0);
    chk("wrap_mem1023", mem[1023], 8'hEF);
    chk("wrap_mem0", mem[0], 8'hBE);
    do_req(0, 1, 0, 10'd1023, 8'h00, 16'h0000, 0);
    // Negative offset: 5 - 8 = 1021.
    do_req(1, 0, 0, 10'd5, 8'hF8, 16'h005A, 0);
    chk("negoff_mem1021", mem[1021], 8'h5A);
    // Back-pressure on a load.
    do_req(0, 1, 0, 10'd1021, 8'h00, 16'h0000, 5);

    // Asynchronous reset during ACC_HI of a wide store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_wide = 1'b1; req_signed = 1'b0;
    req_base = 10'd20; req_offset = 8'h00; req_wdata = 16'h1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    chk("ar_hi_dm_en", dm_en, 1);
    chk("ar_hi_dm_addr", dm_addr, 21);
    rst_n = 1'b0;
    #1;
    chk("ar_dm_en_async", dm_en, 0);
    chk("ar_rsp_valid", rsp_valid, 0);
    ref_mem[20] = 8'h34;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ar_post_req_ready", req_ready, 1);
      chk("ar_post_rsp_valid", rsp_valid, 0);
      chk("ar_post_dm_en", dm_en, 0);
    end
    chk("ar_mem20", mem[20], 8'h34);
    chk("ar_mem21", mem[21], ref_mem[21]);

    // Randomized transactions.
    for (int t = 0; t < 60; t++) begin
      logic [9:0] base;
      base = ($urandom % 8 == 0) ? 10'd1023 : 10'($urandom);
      do_req(1'($urandom), 1'($urandom), 1'($urandom), base,
             8'($urandom), 16'($urandom), int'($urandom % 3));
    end

    // Whole-memory comparison against the reference image.
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (mem[i] !== ref_mem[i]) bad++;
    end
    chk("final_mem_image_errors", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Overall time bound so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_dm_access_unit
`default_nettype wire
